ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  FIFO controller that drives a single-port asynchronous-read RAM (DEPTH x DATA_W).
//  Provides a valid/ready write stream upstream and a valid/ready read stream downstream.
//  One RAM access per cycle: write or read, never both.
//  A one-entry output register holds the head word, so total capacity = DEPTH+1.
// PARAMETERS
//  DATA_W  8   word width; must match the RAM data width
//  ADDR_W  4   RAM address width
//  DEPTH   16  RAM words; must equal 2**ADDR_W
// PORTS
//  clk       in   1         rising-edge clock
//  rst_n     in   1         asynchronous active-low reset
//  wr_valid  in   1         upstream word available
//  wr_ready  out  1         controller accepts wr_data this cycle
//  wr_data   in   DATA_W    upstream word
//  rd_valid  out  1         rd_data holds the FIFO head
//  rd_ready  in   1         downstream consumes the head this cycle
//  rd_data   out  DATA_W    head word (registered)
//  count     out  ADDR_W+1  words held (RAM + output reg), 0..DEPTH+1
//  ram_we    out  1         RAM write enable
//  ram_addr  out  ADDR_W    RAM address
//  ram_din   out  DATA_W    RAM write data
//  ram_dout  in   DATA_W    RAM combinational read data
// BEHAVIOUR
//  State: wr_ptr, rd_ptr (ADDR_W, wrap DEPTH-1 -> 0); mem_cnt (0..DEPTH); oreg, oreg_vld; prio_wr.
//  Reset (rst_n=0, async): ptrs=0, mem_cnt=0, oreg=0, oreg_vld=0, prio_wr=0.
//   During reset: rd_valid=0, rd_data=0, count=0, ram_we=0, wr_ready=0, ram_addr=0.
//  need_fill = !oreg_vld || rd_ready.
//  rd_slot   = need_fill && mem_cnt!=0 && !prio_wr   (combinational).
//  wr_ready  = rst_n && mem_cnt!=DEPTH && !rd_slot.
//   wr_ready never depends on wr_valid.
//  ram_we    = wr_valid && wr_ready.
//  ram_addr  = rd_slot ? rd_ptr : wr_ptr.
//  ram_din   = wr_data.
//  Write slot (ram_we=1): at the edge, wr_ptr++ and mem_cnt++.
//  Read slot (rd_slot=1): at the edge, oreg<=ram_dout, oreg_vld<=1, rd_ptr++, mem_cnt--.
//  Pop (rd_valid && rd_ready) without a read slot: oreg_vld<=0.
//  Pop with a read slot: oreg is replaced, so back-to-back output is possible.
//  Fairness (prio_wr):
//   - set to 1 when a read slot is taken while wr_valid=1;
//   - cleared on any write handshake;
//   - hold otherwise.
//   Under sustained traffic, reads and writes therefore alternate.
//  Full: mem_cnt==DEPTH -> wr_ready=0. count=DEPTH+1 when oreg_vld is also 1.
//  Empty: mem_cnt==0 -> no read slot. rd_valid reflects oreg_vld only.
//  Latency, write -> rd_valid with the FIFO empty: write at edge N, read slot at N+1, rd_valid=1 after N+1.
//  Ordering: strict FIFO. No data is lost or duplicated across pointer wrap.
//  rd_valid=oreg_vld, rd_data=oreg. rd_data holds its value while rd_valid=1 and rd_ready=0.
//  count = mem_cnt + oreg_vld. It updates on the same edge as the handshakes.
//  Reset mid-operation discards all contents; RAM contents are left untouched and ignored.
// CONFIGURATION
//  RAM_FIFO_CTRL_BYPASS_EN defined:
//   - when mem_cnt==0 and (!oreg_vld or pop this cycle), wr_ready=1 and no RAM write happens (ram_we=0);
//   - wr_data loads oreg directly at the edge, so rd_valid=1 one cycle after the write (latency 1).
//  Not defined: every word goes through the RAM (latency 2, as above).
// TESTING
//  1. Reset, then push 0xAA at cycle 0 with rd_ready=0.
//     -> ram_we=1, ram_addr=0 at cycle 0; rd_valid=1, rd_data=0xAA from cycle 2; count=1.
//     (BYPASS_EN: ram_we=0, rd_valid=1 from cycle 1.)
//  2. rd_ready=0, push 17 words 0x00..0x10.
//     -> all accepted, count=17, wr_ready=0.
//     An 18th push stalls; drain returns 0x00..0x10 in order, count ends at 0.
//  3. wr_valid=1 and rd_ready=1 held continuously, DEPTH-word prefill.
//     -> RAM ops alternate write/read each cycle.
//     No starvation; output sequence in order across wrap of both pointers.
//  4. Pop with rd_valid=1 while the RAM is empty and no write.
//     -> rd_valid=0 the next cycle, count=0, ram_we=0.
//  5. Assert rst_n=0 mid-burst with count=9.
//     -> immediately rd_valid=0, count=0, wr_ready=0.
//     After release the first push is read back as a fresh first word.
//  6. Random valid/ready traffic, 2000 cycles, against a reference queue.
//     -> data and order match; count matches the queue length every cycle.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Purpose : FIFO controller for a single-port async-read RAM plus a one-word head register (capacity DEPTH+1).
// Latency : write to rd_valid is 2 cycles through the RAM, or 1 cycle with RAM_FIFO_CTRL_BYPASS_EN defined.
// Backpr. : wr_ready drops when the RAM is full or the RAM port is taken by a read; rd_data is held while rd_ready=0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_data   upstream write stream
//   rd_valid/rd_ready/rd_data   downstream read stream (rd_data is registered)
//   count                       words held in RAM + head register, 0..DEPTH+1
//   ram_we/ram_addr/ram_din     RAM control and write data
//   ram_dout                    RAM combinational read data
//
// Optional feature macro: RAM_FIFO_CTRL_BYPASS_EN
//   When defined, a write into an empty FIFO whose head slot is free (or being popped)
//   goes straight into the head register without touching the RAM.

module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0]   MEM_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH-1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic [DATA_W-1:0] oreg;
  logic              oreg_vld;
  logic              prio_wr;

  logic need_fill;
  logic rd_slot;
  logic pop;
  logic wr_hs;
  logic byp_wr;

  assign need_fill = !oreg_vld || rd_ready;
  assign pop       = oreg_vld && rd_ready;
  // prio_wr yields the single RAM port to a waiting writer right after a read took it.
  assign rd_slot   = need_fill && (mem_cnt != '0) && !prio_wr;
  assign wr_ready  = rst_n && (mem_cnt != MEM_FULL) && !rd_slot;
  assign wr_hs     = wr_valid && wr_ready;

`ifdef RAM_FIFO_CTRL_BYPASS_EN
  // Empty RAM and a free head slot: the word skips the RAM entirely.
  assign byp_wr = wr_hs && (mem_cnt == '0) && need_fill;
`else
  assign byp_wr = 1'b0;
`endif

  assign ram_we   = wr_hs && !byp_wr;
  assign ram_addr = rd_slot ? rd_ptr : wr_ptr;
  assign ram_din  = wr_data;

  assign rd_valid = oreg_vld;
  assign rd_data  = oreg;
  assign count    = mem_cnt + {{ADDR_W{1'b0}}, oreg_vld};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      oreg     <= '0;
      oreg_vld <= 1'b0;
      prio_wr  <= 1'b0;
    end else begin
      if (ram_we) begin
        wr_ptr  <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        mem_cnt <= mem_cnt + 1'b1;
      end

      if (rd_slot) begin
        oreg     <= ram_dout;
        oreg_vld <= 1'b1;
        rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        mem_cnt  <= mem_cnt - 1'b1;
      end else if (byp_wr) begin
        oreg     <= wr_data;
        oreg_vld <= 1'b1;
      end else if (pop) begin
        oreg_vld <= 1'b0;
      end

      if (wr_hs) begin
        prio_wr <= 1'b0;
      end else if (rd_slot && wr_valid) begin
        prio_wr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Purpose : self-checking bench for ram_fifo_ctrl with a behavioural RAM model.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpr. : the driver holds wr_valid/wr_data until accepted; rd_ready is driven directly.

module tb_ram_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic [DATA_W-1:0] mem [DEPTH];

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM: synchronous write, combinational read.
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: count tracks the reference queue, pops are compared in order.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count_vs_model", int'(count), exp_q.size());
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_on_empty_model: got data 0x%0h, expected no word at %0t", rd_data, $time);
        end else begin
          chk("rd_data_order", int'(rd_data), int'(exp_q.pop_front()));
        end
      end
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    bit done = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = wr_ready;
      tick();
    end
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (count == 0 && !rd_valid) done = 1'b1;
      else tick();
    end
    if (!done) chk("drain_timeout", 0, 1);
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    bit hs;
    bit prev_we;

    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: single word latency
    wr_valid = 1'b1; wr_data = 8'hAA;
    @(negedge clk);
`ifdef RAM_FIFO_CTRL_BYPASS_EN
    chk("t1_ram_we_c0", ram_we, 0);
`else
    chk("t1_ram_we_c0", ram_we, 1);
    chk("t1_ram_addr_c0", ram_addr, 0);
`endif
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
`ifdef RAM_FIFO_CTRL_BYPASS_EN
    chk("t1_rd_valid_c1", rd_valid, 1);
`else
    chk("t1_rd_valid_c1", rd_valid, 0);
`endif
    tick();
    @(negedge clk);
    chk("t1_rd_valid_c2", rd_valid, 1);
    chk("t1_rd_data_c2", rd_data, 8'hAA);
    chk("t1_count_c2", count, 1);
    tick();
    drain();

    // 2: fill to DEPTH+1, stall, drain in order
    for (int i = 0; i <= DEPTH; i++) push_word(8'(i));
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t2_count_full", count, DEPTH + 1);
    chk("t2_wr_ready_full", wr_ready, 0);
    tick();
    wr_valid = 1'b1; wr_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_push18_stall", wr_ready, 0);
      tick();
    end
    wr_valid = 1'b0;
    drain();
    chk("t2_count_end", count, 0);

    // 4: pop the last word with an empty RAM and no write
    push_word(8'h3C);
    wr_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t4_rd_valid_before", rd_valid, 1);
    tick();
    rd_ready = 1'b1;
    @(negedge clk);
    chk("t4_ram_we_pop", ram_we, 0);
    tick();
    rd_ready = 1'b0;
    @(negedge clk);
    chk("t4_rd_valid_after", rd_valid, 0);
    chk("t4_count_after", count, 0);
    tick();

    // 3: DEPTH-word prefill, then sustained write+read traffic across wraps
    for (int i = 0; i < DEPTH; i++) push_word(8'h40 + 8'(i));
    rd_ready = 1'b1;
    wr_data  = 8'h40 + 8'(DEPTH);
    hs = 1'b0;
    prev_we = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      if (i > 0) chk("t3_alternate", ram_we, int'(!prev_we));
      prev_we = ram_we;
      tick();
      if (hs) wr_data = wr_data + 1'b1;
      if (i >= 60 && hs) break;
    end
    wr_valid = 1'b0;
    drain();

    // 6: random traffic against the reference queue
    hs = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!wr_valid || hs) begin
        wr_valid = ($urandom_range(0, 2) != 0);
        wr_data  = 8'($urandom);
      end
      rd_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
      hs = wr_valid && wr_ready;
      tick();
    end
    for (int i = 0; i < 50 && wr_valid && !hs; i++) begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    drain();

    // 5: reset in the middle of a burst
    for (int i = 0; i < 9; i++) push_word(8'h90 + 8'(i));
    wr_data = 8'h77;
    @(negedge clk);
    chk("t5_count_before", count, 9);
    tick();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_rd_valid", rd_valid, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_wr_ready", wr_ready, 0);
    chk("t5_rst_ram_we", ram_we, 0);
    wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    push_word(8'h5C);
    wr_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t5_first_valid", rd_valid, 1);
    chk("t5_first_data", rd_data, 8'h5C);
    chk("t5_first_count", count, 1);
    tick();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
